// File: rtl/dwc_axis.sv
// AXI-Stream data-width converter. It packs narrow beats into wide words (UP),
// splits wide words into narrow beats (DOWN), or acts as a register slice (PASS).
module dwc_axis #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
    input  logic                 s_axis_input_tvalid,
    output logic                 s_axis_input_tready,
    input  logic                 s_axis_input_tlast,
    output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
    output logic                 m_axis_output_tvalid,
    input  logic                 m_axis_output_tready,
    output logic                 m_axis_output_tlast
);
    localparam int MAX_W = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int MIN_RAW = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int MIN_W = (MIN_RAW > 0) ? MIN_RAW : 1;
    localparam int RATIO = MAX_W / MIN_W;

    generate
        if (IN_WIDTH <= 0 || OUT_WIDTH <= 0) begin : g_bad_width
            $fatal(1, "dwc_axis: IN_WIDTH and OUT_WIDTH must be positive");
        end
        if ((MAX_W % MIN_W) != 0) begin : g_bad_ratio
            $fatal(1, "dwc_axis: wider width must be an integer multiple of the narrower");
        end
    endgenerate

    // Input ready is held low through reset and rises on the first edge after release.
    logic r_alive;
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_up
            localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
            localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

            logic [OUT_WIDTH-1:0] r_asm;
            logic [OUT_WIDTH-1:0] r_outData;
            logic [CW-1:0]        r_cnt;
            logic                 r_outValid;
            logic                 r_outLast;
            logic [OUT_WIDTH-1:0] w_merged;
            logic                 w_inReady;
            logic                 w_inFire;
            logic                 w_outFire;
            logic                 w_complete;

            assign w_inReady  = r_alive && (!r_outValid || m_axis_output_tready);
            assign w_inFire   = s_axis_input_tvalid && w_inReady;
            assign w_outFire  = r_outValid && m_axis_output_tready;
            assign w_complete = (r_cnt == LAST_IDX) || s_axis_input_tlast;

            // The assembly register is all-zero above the fill point, so unwritten slices pad with 0.
            always_comb begin
                w_merged = r_asm;
                for (int k = 0; k < RATIO; k++) begin
                    if (r_cnt == CW'(k)) begin
                        w_merged[k*IN_WIDTH +: IN_WIDTH] = s_axis_input_tdata;
                    end
                end
            end

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    r_asm      <= '0;
                    r_outData  <= '0;
                    r_cnt      <= '0;
                    r_outValid <= 1'b0;
                    r_outLast  <= 1'b0;
                end else begin
                    if (w_outFire) begin
                        r_outValid <= 1'b0;
                    end
                    if (w_inFire) begin
                        if (w_complete) begin
                            r_outData  <= w_merged;
                            r_outValid <= 1'b1;
                            r_outLast  <= s_axis_input_tlast;
                            r_asm      <= '0;
                            r_cnt      <= '0;
                        end else begin
                            r_asm <= w_merged;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            end

            assign s_axis_input_tready  = w_inReady;
            assign m_axis_output_tdata  = r_outData;
            assign m_axis_output_tvalid = r_outValid;
            assign m_axis_output_tlast  = r_outLast;
        end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
            localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
            localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

            logic [IN_WIDTH-1:0]  r_word;
            logic [CW-1:0]        r_idx;
            logic                 r_valid;
            logic                 r_wordLast;
            logic [OUT_WIDTH-1:0] w_slice;
            logic                 w_lastSlice;
            logic                 w_inReady;
            logic                 w_inFire;
            logic                 w_outFire;

            assign w_lastSlice = (r_idx == LAST_IDX);
            assign w_inReady   = r_alive && (!r_valid || (m_axis_output_tready && w_lastSlice));
            assign w_inFire    = s_axis_input_tvalid && w_inReady;
            assign w_outFire   = r_valid && m_axis_output_tready;

            always_comb begin
                w_slice = '0;
                for (int k = 0; k < RATIO; k++) begin
                    if (r_idx == CW'(k)) begin
                        w_slice = r_word[k*OUT_WIDTH +: OUT_WIDTH];
                    end
                end
            end

            // A new word accepted on the last slice's transfer overrides the empty/wrap update.
            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    r_word     <= '0;
                    r_idx      <= '0;
                    r_valid    <= 1'b0;
                    r_wordLast <= 1'b0;
                end else begin
                    if (w_outFire) begin
                        if (w_lastSlice) begin
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    if (w_inFire) begin
                        r_word     <= s_axis_input_tdata;
                        r_wordLast <= s_axis_input_tlast;
                        r_valid    <= 1'b1;
                        r_idx      <= '0;
                    end
                end
            end

            assign s_axis_input_tready  = w_inReady;
            assign m_axis_output_tdata  = w_slice;
            assign m_axis_output_tvalid = r_valid;
            assign m_axis_output_tlast  = r_valid && r_wordLast && w_lastSlice;
        end else begin : g_pass
            logic [OUT_WIDTH-1:0] r_data;
            logic                 r_valid;
            logic                 r_last;
            logic                 w_inReady;
            logic                 w_inFire;
            logic                 w_outFire;

            assign w_inReady = r_alive && (!r_valid || m_axis_output_tready);
            assign w_inFire  = s_axis_input_tvalid && w_inReady;
            assign w_outFire = r_valid && m_axis_output_tready;

            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    if (w_outFire) begin
                        r_valid <= 1'b0;
                    end
                    if (w_inFire) begin
                        r_data  <= s_axis_input_tdata;
                        r_valid <= 1'b1;
                        r_last  <= s_axis_input_tlast;
                    end
                end
            end

            assign s_axis_input_tready  = w_inReady;
            assign m_axis_output_tdata  = r_data;
            assign m_axis_output_tvalid = r_valid;
            assign m_axis_output_tlast  = r_last;
        end
    endgenerate
endmodule

// File: tb/tb_dwc_axis.sv
// Directed bench for dwc_axis: four converter instances (8->32, 32->8, 8->24, 24->8)
// sharing one clock and reset, exercised one scenario task at a time.
module tb_dwc_axis;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    logic [7:0]  u32InData;
    logic        u32InValid, u32InReady, u32InLast;
    logic [31:0] u32OutData;
    logic        u32OutValid, u32OutReady, u32OutLast;

    logic [31:0] d32InData;
    logic        d32InValid, d32InReady, d32InLast;
    logic [7:0]  d32OutData;
    logic        d32OutValid, d32OutReady, d32OutLast;

    logic [7:0]  u24InData;
    logic        u24InValid, u24InReady, u24InLast;
    logic [23:0] u24OutData;
    logic        u24OutValid, u24OutReady, u24OutLast;

    logic [23:0] d24InData;
    logic        d24InValid, d24InReady, d24InLast;
    logic [7:0]  d24OutData;
    logic        d24OutValid, d24OutReady, d24OutLast;

    dwc_axis #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_up32 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input_tdata(u32InData), .s_axis_input_tvalid(u32InValid),
        .s_axis_input_tready(u32InReady), .s_axis_input_tlast(u32InLast),
        .m_axis_output_tdata(u32OutData), .m_axis_output_tvalid(u32OutValid),
        .m_axis_output_tready(u32OutReady), .m_axis_output_tlast(u32OutLast)
    );

    dwc_axis #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dn32 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input_tdata(d32InData), .s_axis_input_tvalid(d32InValid),
        .s_axis_input_tready(d32InReady), .s_axis_input_tlast(d32InLast),
        .m_axis_output_tdata(d32OutData), .m_axis_output_tvalid(d32OutValid),
        .m_axis_output_tready(d32OutReady), .m_axis_output_tlast(d32OutLast)
    );

    dwc_axis #(.IN_WIDTH(8), .OUT_WIDTH(24)) u_up24 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input_tdata(u24InData), .s_axis_input_tvalid(u24InValid),
        .s_axis_input_tready(u24InReady), .s_axis_input_tlast(u24InLast),
        .m_axis_output_tdata(u24OutData), .m_axis_output_tvalid(u24OutValid),
        .m_axis_output_tready(u24OutReady), .m_axis_output_tlast(u24OutLast)
    );

    dwc_axis #(.IN_WIDTH(24), .OUT_WIDTH(8)) u_dn24 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_input_tdata(d24InData), .s_axis_input_tvalid(d24InValid),
        .s_axis_input_tready(d24InReady), .s_axis_input_tlast(d24InLast),
        .m_axis_output_tdata(d24OutData), .m_axis_output_tvalid(d24OutValid),
        .m_axis_output_tready(d24OutReady), .m_axis_output_tlast(d24OutLast)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_all();
        u32InData = '0; u32InValid = 1'b0; u32InLast = 1'b0; u32OutReady = 1'b1;
        d32InData = '0; d32InValid = 1'b0; d32InLast = 1'b0; d32OutReady = 1'b1;
        u24InData = '0; u24InValid = 1'b0; u24InLast = 1'b0; u24OutReady = 1'b1;
        d24InData = '0; d24InValid = 1'b0; d24InLast = 1'b0; d24OutReady = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({u32OutValid, u32OutLast, u32OutData} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_up_out got v=%0b l=%0b d=%h want 0/0/0", u32OutValid, u32OutLast, u32OutData);
        end
        checks++;
        if ({d32OutValid, d32OutLast, d32OutData} !== 10'h0) begin
            errors++;
            $display("[TB] FAIL reset_dn_out got v=%0b l=%0b d=%h want 0/0/0", d32OutValid, d32OutLast, d32OutData);
        end
        checks++;
        if ({u32InReady, d32InReady, u24InReady, d24InReady} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ready_low got %b want 0000", {u32InReady, d32InReady, u24InReady, d24InReady});
        end
        ap_rst = 1'b0;
        tick();
        checks++;
        if ({u32InReady, d32InReady, u24InReady, d24InReady} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_ready_high got %b want 1111", {u32InReady, d32InReady, u24InReady, d24InReady});
        end
    endtask

    task automatic test_up_basic();
        u32OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u32InData = 8'((i + 1) * 17);
            u32InLast = (i == 3);
            u32InValid = 1'b1;
            #1;
            checks++;
            if ({u32InReady, u32OutValid} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL up_basic_pre%0d got rdy=%0b v=%0b want 1/0", i, u32InReady, u32OutValid);
            end
            tick();
        end
        u32InValid = 1'b0; u32InLast = 1'b0;
        checks++;
        if ({u32OutValid, u32OutLast, u32OutData} !== {1'b1, 1'b1, 32'h44332211}) begin
            errors++;
            $display("[TB] FAIL up_basic_word got v=%0b l=%0b d=%h want 1/1/44332211", u32OutValid, u32OutLast, u32OutData);
        end
        tick();
        checks++;
        if (u32OutValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL up_basic_oneshot got v=%0b want 0", u32OutValid);
        end
    endtask

    task automatic test_up_partial();
        logic [7:0] beats [6] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
        u32OutReady = 1'b1;
        for (int j = 0; j < 6; j++) begin
            u32InData = beats[j];
            u32InLast = (j == 1);
            u32InValid = 1'b1;
            tick();
            checks++;
            if (j == 1) begin
                if ({u32OutValid, u32OutLast, u32OutData} !== {1'b1, 1'b1, 32'h0000BBAA}) begin
                    errors++;
                    $display("[TB] FAIL up_partial_flush got v=%0b l=%0b d=%h want 1/1/0000bbaa", u32OutValid, u32OutLast, u32OutData);
                end
            end else if (j == 5) begin
                if ({u32OutValid, u32OutLast, u32OutData} !== {1'b1, 1'b0, 32'h04030201}) begin
                    errors++;
                    $display("[TB] FAIL up_partial_next got v=%0b l=%0b d=%h want 1/0/04030201", u32OutValid, u32OutLast, u32OutData);
                end
            end else if (u32OutValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL up_partial_idle%0d got v=%0b want 0", j, u32OutValid);
            end
        end
        u32InValid = 1'b0; u32InLast = 1'b0;
    endtask

    task automatic test_down_basic();
        logic [7:0] expB [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        logic accepted;
        d32OutReady = 1'b1;
        d32InData = 32'hDDCCBBAA; d32InLast = 1'b1; d32InValid = 1'b1;
        #1;
        checks++;
        if (d32InReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dn_basic_ready got %0b want 1", d32InReady);
        end
        tick();
        d32InData = 32'h44332211; d32InLast = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if ({d32OutValid, d32OutLast, d32OutData} !== {1'b1, (k == 3), expB[k]}) begin
                errors++;
                $display("[TB] FAIL dn_basic_beat%0d got v=%0b l=%0b d=%h want 1/%0b/%h", k, d32OutValid, d32OutLast, d32OutData, (k == 3), expB[k]);
            end
            accepted = d32InValid && d32InReady;
            tick();
            if (accepted) d32InValid = 1'b0;
        end
        checks++;
        if (d32OutValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dn_basic_empty got v=%0b want 0", d32OutValid);
        end
    endtask

    task automatic test_throughput();
        int stalls = 0;
        int words = 0;
        int outCount = 0;
        int gaps = 0;
        int w = 0;
        logic accepted;
        u32OutReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            u32InData = 8'(i);
            u32InValid = 1'b1;
            #1;
            if (!u32InReady) stalls++;
            tick();
            if (u32OutValid) begin
                checks++;
                if (u32OutData !== 32'h03020100 + 32'(words) * 32'h04040404) begin
                    errors++;
                    $display("[TB] FAIL thr_up_word%0d got %h want %h", words, u32OutData, 32'h03020100 + 32'(words) * 32'h04040404);
                end
                words++;
            end
        end
        u32InValid = 1'b0;
        checks++;
        if (stalls != 0 || words != 3) begin
            errors++;
            $display("[TB] FAIL thr_up_rate got stalls=%0d words=%0d want 0/3", stalls, words);
        end

        d32OutReady = 1'b1;
        d32InData = 32'h03020100; d32InLast = 1'b0; d32InValid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            accepted = d32InValid && d32InReady;
            tick();
            if (accepted) begin
                w++;
                if (w == 3) d32InValid = 1'b0;
                else d32InData = 32'h03020100 + 32'(w) * 32'h04040404;
            end
            if (d32OutValid) begin
                checks++;
                if (d32OutData !== 8'(outCount)) begin
                    errors++;
                    $display("[TB] FAIL thr_dn_beat%0d got %h want %h", outCount, d32OutData, 8'(outCount));
                end
                outCount++;
            end else if (outCount > 0 && outCount < 12) begin
                gaps++;
            end
        end
        checks++;
        if (outCount != 12 || gaps != 0) begin
            errors++;
            $display("[TB] FAIL thr_dn_rate got beats=%0d gaps=%0d want 12/0", outCount, gaps);
        end
    endtask

    task automatic test_random();
        logic [23:0] upQ [$];
        logic        upLQ [$];
        logic [7:0]  dnQ [$];
        logic        dnLQ [$];
        logic [23:0] asmWord = '0;
        int asmCnt = 0;
        int upSent = 0;
        int dnSent = 0;
        int cycles = 0;
        logic upFireIn, upFireOut, dnFireIn, dnFireOut, upHold, dnHold;
        logic [24:0] upHeld;
        logic [8:0]  dnHeld;
        logic [23:0] expW;
        logic [7:0]  expB;
        logic        expL;
        while ((upSent < 1000 || dnSent < 340 || upQ.size() > 0 || dnQ.size() > 0) && cycles < 30000) begin
            if (!u24InValid && upSent < 1000 && $urandom_range(1) == 1) begin
                u24InValid = 1'b1;
                u24InData = 8'($urandom);
                u24InLast = (upSent == 999) || ($urandom_range(4) == 0);
            end
            if (!d24InValid && dnSent < 340 && $urandom_range(1) == 1) begin
                d24InValid = 1'b1;
                d24InData = 24'($urandom);
                d24InLast = ($urandom_range(2) == 0);
            end
            u24OutReady = ($urandom_range(1) == 1);
            d24OutReady = ($urandom_range(1) == 1);
            #1;
            upFireIn = u24InValid && u24InReady;
            upFireOut = u24OutValid && u24OutReady;
            dnFireIn = d24InValid && d24InReady;
            dnFireOut = d24OutValid && d24OutReady;
            upHold = u24OutValid && !u24OutReady;
            dnHold = d24OutValid && !d24OutReady;
            upHeld = {u24OutLast, u24OutData};
            dnHeld = {d24OutLast, d24OutData};
            if (upFireOut) begin
                checks++;
                if (upQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL up_rand_extra got %h want no beat", u24OutData);
                end else begin
                    expW = upQ.pop_front();
                    expL = upLQ.pop_front();
                    if ({u24OutLast, u24OutData} !== {expL, expW}) begin
                        errors++;
                        $display("[TB] FAIL up_rand_data got l=%0b d=%h want l=%0b d=%h", u24OutLast, u24OutData, expL, expW);
                    end
                end
            end
            if (dnFireOut) begin
                checks++;
                if (dnQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL dn_rand_extra got %h want no beat", d24OutData);
                end else begin
                    expB = dnQ.pop_front();
                    expL = dnLQ.pop_front();
                    if ({d24OutLast, d24OutData} !== {expL, expB}) begin
                        errors++;
                        $display("[TB] FAIL dn_rand_data got l=%0b d=%h want l=%0b d=%h", d24OutLast, d24OutData, expL, expB);
                    end
                end
            end
            if (upFireIn) begin
                asmWord = asmWord | (24'(u24InData) << (8 * asmCnt));
                if (asmCnt == 2 || u24InLast) begin
                    upQ.push_back(asmWord);
                    upLQ.push_back(u24InLast);
                    asmWord = '0;
                    asmCnt = 0;
                end else begin
                    asmCnt++;
                end
                upSent++;
            end
            if (dnFireIn) begin
                for (int k = 0; k < 3; k++) begin
                    dnQ.push_back(8'(d24InData >> (8 * k)));
                    dnLQ.push_back(d24InLast && (k == 2));
                end
                dnSent++;
            end
            tick();
            if (upHold) begin
                checks++;
                if ({u24OutValid, u24OutLast, u24OutData} !== {1'b1, upHeld}) begin
                    errors++;
                    $display("[TB] FAIL up_rand_stable got v=%0b ld=%h want 1/%h", u24OutValid, {u24OutLast, u24OutData}, upHeld);
                end
            end
            if (dnHold) begin
                checks++;
                if ({d24OutValid, d24OutLast, d24OutData} !== {1'b1, dnHeld}) begin
                    errors++;
                    $display("[TB] FAIL dn_rand_stable got v=%0b ld=%h want 1/%h", d24OutValid, {d24OutLast, d24OutData}, dnHeld);
                end
            end
            if (upFireIn) u24InValid = 1'b0;
            if (dnFireIn) d24InValid = 1'b0;
            cycles++;
        end
        checks++;
        if (upSent != 1000 || upQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL up_rand_drain got sent=%0d pending=%0d want 1000/0", upSent, upQ.size());
        end
        checks++;
        if (dnSent != 340 || dnQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL dn_rand_drain got sent=%0d pending=%0d want 340/0", dnSent, dnQ.size());
        end
        idle_all();
    endtask

    task automatic test_reset_midop();
        u32OutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u32InData = 8'hA0 + 8'(i);
            u32InValid = 1'b1;
            tick();
        end
        u32InValid = 1'b0;
        checks++;
        if ({u32OutValid, u32OutData} !== {1'b1, 32'hA3A2A1A0}) begin
            errors++;
            $display("[TB] FAIL rst_held_word got v=%0b d=%h want 1/a3a2a1a0", u32OutValid, u32OutData);
        end
        #2 ap_rst = 1'b1;
        #1;
        checks++;
        if ({u32OutValid, u32OutData, u32InReady} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL rst_async_drop got v=%0b d=%h rdy=%0b want 0/0/0", u32OutValid, u32OutData, u32InReady);
        end
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        u32OutReady = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            u32InData = 8'h99 + 8'(i);
            u32InValid = 1'b1;
            tick();
        end
        u32InValid = 1'b0;
        #2 ap_rst = 1'b1;
        #1;
        checks++;
        if ({u32OutValid, u32OutLast} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_partial_drop got v=%0b l=%0b want 0/0", u32OutValid, u32OutLast);
        end
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            u32InData = 8'h55 + 8'(i) * 8'h11;
            u32InValid = 1'b1;
            tick();
        end
        u32InValid = 1'b0;
        checks++;
        if ({u32OutValid, u32OutLast, u32OutData} !== {1'b1, 1'b0, 32'h88776655}) begin
            errors++;
            $display("[TB] FAIL rst_new_word got v=%0b l=%0b d=%h want 1/0/88776655", u32OutValid, u32OutLast, u32OutData);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_up_basic();
        idle_all(); tick(); tick();
        test_up_partial();
        idle_all(); tick(); tick();
        test_down_basic();
        idle_all(); tick(); tick();
        test_throughput();
        idle_all(); tick(); tick();
        test_random();
        idle_all(); tick(); tick();
        test_reset_midop();
        idle_all(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dwc_axis.md
Name: dwc_axis

Overview:
- Generic AXI-Stream data-width converter for the dataflow pipeline, placed between layers whose stream widths differ by an integer ratio.
- Supports upsizing (packs several narrow input beats into one wide output beat) and downsizing (splits one wide input beat into several narrow output beats).
- Compared with the previous upsample-only converter, it adds:
  - both directions, plus a pass-through register slice when widths are equal;
  - full-throughput AXI handshakes with no bubble at word boundaries;
  - TLAST-driven early flush of a partially filled word.

Parameters:
- IN_WIDTH, 8, input tdata width in bits; must be > 0.
- OUT_WIDTH, 32, output tdata width in bits; must be > 0.
- Derived, not overridable: RATIO = max(IN_WIDTH,OUT_WIDTH)/min(IN_WIDTH,OUT_WIDTH).
- Derived, not overridable: MODE = UP if OUT_WIDTH>IN_WIDTH, DOWN if IN_WIDTH>OUT_WIDTH, else PASS.
- Elaboration check: the larger width must be an exact multiple of the smaller, otherwise a fatal elaboration error.

Ports:
- ap_clk  in  1  single clock; all logic is on the rising edge.
- ap_rst  in  1  reset, asynchronous and active-high.
- s_axis_input_tdata  in  IN_WIDTH  input data.
- s_axis_input_tvalid  in  1  input valid.
- s_axis_input_tready  out  1  input ready.
- s_axis_input_tlast  in  1  end-of-frame marker.
- m_axis_output_tdata  out  OUT_WIDTH  output data.
- m_axis_output_tvalid  out  1  output valid.
- m_axis_output_tready  in  1  output ready.
- m_axis_output_tlast  out  1  end-of-frame marker.

Behaviour:
- Reset (asynchronous assert; registers update on the clock edge after release):
  - m_axis_output_tvalid=0, m_axis_output_tlast=0, m_axis_output_tdata=0, all counters=0.
  - s_axis_input_tready=0 while ap_rst is high; it becomes 1 on the first cycle after release.
- Handshake rules:
  - A transfer occurs on a rising edge with valid&&ready.
  - The output holds tvalid, tdata and tlast stable until accepted.
  - No combinational path from s_axis_input_tvalid to s_axis_input_tready.
- Beat ordering: little-endian. The first narrow beat occupies bits [W-1:0] of the wide word, where W is the narrow width.
- PASS mode:
  - A single-entry register slice; latency 1 cycle.
  - s_axis_input_tready = !out_valid || m_axis_output_tready.
- UP mode (packing):
  - State: assembly register (OUT_WIDTH), fill counter cnt in 0..RATIO-1, output register with valid/last.
  - Each accepted input is written to slice cnt of the assembly register.
  - If cnt==RATIO-1 or tlast=1:
    - the assembled word moves to the output register (slices not yet written are forced to 0);
    - out_last = tlast;
    - cnt is cleared to 0.
  - Otherwise cnt increments.
  - s_axis_input_tready = !out_valid || m_axis_output_tready.
  - When the output is consumed in the same cycle a completing input arrives, the new word loads with no bubble. Sustained rate is 1 input beat per cycle.
  - Latency: 1 cycle from the completing input beat to output valid.
  - Zero padding: the assembly register is cleared after each transfer to the output, so a partial (tlast-flushed) word has zeros above the last written slice.
  - A tlast on the final slice of a full word behaves as a normal completion with out_last=1.
- DOWN mode (splitting):
  - State: word register (IN_WIDTH), slice index idx in 0..RATIO-1, valid, word_last.
  - m_axis_output_tdata = slice idx of the word register.
  - m_axis_output_tlast = word_last && (idx==RATIO-1).
  - On each output transfer:
    - if idx<RATIO-1, idx increments;
    - otherwise idx returns to 0 and valid clears, unless a new input is accepted in the same cycle.
  - s_axis_input_tready = !valid || (m_axis_output_tready && idx==RATIO-1).
  - Sustained rate is 1 output beat per cycle across word boundaries.
  - Latency: 1 cycle from input acceptance to the first output slice.
- Widths:
  - Counters are $clog2(RATIO) bits, minimum 1.
  - When RATIO is not a power of two, wrap is by explicit compare to RATIO-1, never by overflow.
- Backpressure: with m_axis_output_tready=0 indefinitely, no data is lost or duplicated. The block holds at most one complete output word plus one partial assembly (UP), or one word (DOWN).
- Reset mid-operation: any partial assembly or pending slices are discarded. The first beat after reset starts a new word at slice 0.

Test Plan:
- UP, IN=8, OUT=32, m_axis_output_tready=1; inputs 0x11,0x22,0x33,0x44 on consecutive cycles with tlast only on 0x44 -> one output 0x44332211, tlast=1, tvalid high exactly one cycle after 0x44 is accepted.
- UP partial flush: inputs 0xAA, then 0xBB with tlast=1 -> output 0x0000BBAA with tlast=1; the next inputs 0x01..0x04 -> 0x04030201 with no stale bytes.
- DOWN, IN=32, OUT=8: input 0xDDCCBBAA with tlast=1, then 0x44332211 with tlast=0, sink always ready -> outputs AA,BB,CC,DD,11,22,33,44 on 8 consecutive cycles with no gap; tlast=1 only on DD.
- Random tvalid/tready toggling (50%) on UP 8->24 (RATIO=3, non-power-of-two) and DOWN 24->8, 1000 beats -> the output stream equals the scoreboard model; tdata stable while tvalid&&!tready; no drops.
- Throughput: UP 8->32 and DOWN 32->8 with source always valid and sink always ready -> exactly 1 input beat per cycle (UP) and 1 output beat per cycle (DOWN) after the first word.
- Reset: assert ap_rst asynchronously (off the clock edge) after 2 of 4 UP input beats -> tvalid drops to 0 immediately. After release, beats 0x55,0x66,0x77,0x88 -> 0x88776655.
